adder_pipe_ctrl: RTL and testbench

ADDER_PIPE_CTRL -- requirements
Module: adder_pipe_ctrl

---
 rtl/adder_pipe_ctrl_if.sv | 25 ++
 rtl/adder_pipe_ctrl.sv | 79 +++++++
 tb/tb_adder_pipe_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_ctrl_if.sv
// Handshake bundle between the adder pipeline controller and its upstream/downstream neighbours.
// The master side drives operands and the flush request, and the controller is the slave.
interface adder_pipe_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;
    logic flush_req;

    modport master (
        output in_valid,
        output out_ready,
        output flush_req,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        input  flush_req,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/adder_pipe_ctrl.sv
// Valid/ready control for a STAGES-deep four-input adder pipeline: per-stage enables and flushes,
// bubble-collapsing backpressure, an occupancy count and a saturating output-stall counter.
module adder_pipe_ctrl #(
    parameter int STAGES  = 3,
    parameter int STALL_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    adder_pipe_ctrl_if.slave              hs,
    output logic [STAGES-1:0]             stage_en,
    output logic [STAGES-1:0]             stage_flush,
    output logic [STAGES-1:0]             stage_valid,
    output logic [$clog2(STAGES+1)-1:0]   occupancy,
    output logic                          busy,
    output logic [STALL_W-1:0]            stall_cycles
);
    localparam int OCC_W = $clog2(STAGES+1);

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] x);
        return (&x) ? x : x + 1'b1;
    endfunction

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] x);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int k = 0; k < STAGES; k++) n = n + OCC_W'(x[k]);
        return n;
    endfunction

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] u;
    logic [STAGES-1:0] rdy;
    logic              kill;
    logic              xfer;

    // Ready ripples from the output back to the input; an empty stage is always ready.
    always_comb begin
        logic r;
        rdy = '0;
        r   = hs.out_ready;
        for (int k = STAGES-1; k >= 0; k--) begin
            r      = ~v[k] | r;
            rdy[k] = r;
        end
    end

    assign u           = {v[STAGES-2:0], hs.in_valid};
    assign kill        = rst | hs.flush_req;
    assign stage_en    = kill ? '0 : (rdy & u);
    assign stage_flush = {STAGES{kill}};
    assign stage_valid = v;
    assign hs.in_ready = rdy[0] & ~hs.flush_req & ~rst;
    assign hs.out_valid = v[STAGES-1];
    assign xfer        = v[STAGES-1] & hs.out_ready;
    assign occupancy   = popcount(v);
    assign busy        = |v;

    // Stage valid flags: advance where ready, hold where blocked, clear on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
        end else if (hs.flush_req) begin
            v <= '0;
        end else begin
            v <= (rdy & u) | (~rdy & v);
        end
    end

    // Output stall counter: counts held results, cleared by transfer or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (hs.flush_req || xfer) begin
            stall_cycles <= '0;
        end else if (v[STAGES-1]) begin
            stall_cycles <= sat_inc(stall_cycles);
        end
    end
endmodule

// File: tb/tb_adder_pipe_ctrl.sv
// Bench for adder_pipe_ctrl: directed control checks plus a token scoreboard that carries
// tags through a model datapath steered by the controller's stage enables.
module tb_adder_pipe_ctrl;
    localparam int STAGES  = 3;
    localparam int STALL_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic [STAGES-1:0]  stage_en, stage_flush, stage_valid;
    logic [1:0]         occupancy;
    logic               busy;
    logic [STALL_W-1:0] stall_cycles;

    adder_pipe_ctrl_if hs ();

    adder_pipe_ctrl #(.STAGES(STAGES), .STALL_W(STALL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .hs           (hs.slave),
        .stage_en     (stage_en),
        .stage_flush  (stage_flush),
        .stage_valid  (stage_valid),
        .occupancy    (occupancy),
        .busy         (busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int unsigned sb[$];
    int unsigned tok = 1;
    int unsigned d [STAGES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor and model datapath, evaluated each negedge with inputs stable.
    initial begin
        for (int k = 0; k < STAGES; k++) d[k] = 0;
        forever begin
            @(negedge clk);
            if (hs.out_valid && hs.out_ready && !hs.flush_req && !rst) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", d[STAGES-1], 32'hFFFF_FFFF);
                end else begin
                    check("sb_data", d[STAGES-1], sb.pop_front());
                end
            end
            if (hs.in_valid && hs.in_ready) sb.push_back(tok);
            for (int k = STAGES-1; k > 0; k--) if (stage_en[k]) d[k] = d[k-1];
            if (stage_en[0]) d[0] = tok;
            if (hs.in_valid && hs.in_ready) tok++;
        end
    end

    localparam logic [7:0] BUB_IV = 8'b0101_0001;
    logic [2:0] bub_v [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b101, 3'b110, 3'b111};

    initial begin
        rst = 1'b1;
        hs.in_valid  = 1'b1;
        hs.out_ready = 1'b1;
        hs.flush_req = 1'b0;

        // Reset with input offered, before any clock edge.
        #3;
        check("rst_in_ready", hs.in_ready, 0);
        check("rst_flush", stage_flush, 3'b111);
        check("rst_occ", occupancy, 0);
        check("rst_en", stage_en, 0);
        check("rst_out_valid", hs.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_stall", stall_cycles, 0);

        // Streaming from the first cycle after reset.
        step();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) step();
            @(negedge clk);
            if (c == 0) begin
                check("rel_in_ready", hs.in_ready, 1);
                check("rel_flush", stage_flush, 3'b000);
            end
            check("str_out_valid", hs.out_valid, (c >= 3) ? 1 : 0);
            check("str_occ", occupancy, (c >= 3) ? 3 : c);
            check("str_en", stage_en, (c == 0) ? 3'b001 : (c == 1) ? 3'b011 : 3'b111);
            if (c >= 3) check("full_push_pop_rdy", hs.in_ready, 1);
        end

        // Backpressure on a full pipe.
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 0) hs.out_ready = 1'b0;
            @(negedge clk);
            check("bp_stall", stall_cycles, (i < 255) ? i : 255);
            check("bp_in_ready", hs.in_ready, 0);
            check("bp_en", stage_en, 0);
        end
        step();
        hs.out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_in_ready", hs.in_ready, 1);
        check("bp_rel_en", stage_en, 3'b111);
        check("bp_rel_stall", stall_cycles, 255);
        step();
        @(negedge clk);
        check("bp_stall_clear", stall_cycles, 0);
        check("bp_occ", occupancy, 3);

        // Drain to empty.
        step();
        hs.in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("drain_busy", busy, 0);

        // Bubble collapse under backpressure.
        for (int c = 0; c < 8; c++) begin
            step();
            hs.out_ready = 1'b0;
            hs.in_valid  = BUB_IV[c];
            @(negedge clk);
            check("bub_valid", stage_valid, bub_v[c]);
        end
        check("bub_full_in_ready", hs.in_ready, 0);
        step();
        hs.out_ready = 1'b1;
        hs.in_valid  = 1'b0;
        @(negedge clk);
        check("pre_flush_valid", stage_valid, 3'b111);

        // Flush with two stages occupied and input offered.
        step();
        hs.flush_req = 1'b1;
        hs.in_valid  = 1'b1;
        sb.delete();
        @(negedge clk);
        check("fl_occ_before", occupancy, 2);
        check("fl_in_ready", hs.in_ready, 0);
        check("fl_flush", stage_flush, 3'b111);
        check("fl_en", stage_en, 0);
        step();
        hs.flush_req = 1'b0;
        hs.in_valid  = 1'b0;
        @(negedge clk);
        check("fl_occ_after", occupancy, 0);
        check("fl_out_valid", hs.out_valid, 0);
        check("fl_busy", busy, 0);
        check("fl_stall", stall_cycles, 0);

        // Reset asserted mid-stream takes effect without a clock edge.
        step();
        hs.in_valid = 1'b1;
        repeat (2) step();
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_in_ready", hs.in_ready, 0);
        check("mid_rst_flush", stage_flush, 3'b111);
        check("mid_rst_out_valid", hs.out_valid, 0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", hs.in_ready, 1);
        check("post_rst_valid", stage_valid, 0);
        repeat (6) step();
        hs.in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("end_busy", busy, 0);
        check("sb_leftover", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
